// File: rtl/alu_sequencer_pkg.sv
// Shared opcode/state encodings and flag type for the ALU sequencer.
// Also holds the flag helper used by the logic operations.
package alu_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_XNOR = 3'b011,
        OP_NOTA = 3'b100,
        OP_ADD  = 3'b101,
        OP_SUB  = 3'b110,
        OP_MUL  = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam logic [4:0] MUL_LAST_CNT = 5'd31;

    function automatic flags_t logic_flags(input logic [31:0] r);
        flags_t f;
        f.n = r[31];
        f.z = (r == 32'd0);
        f.c = 1'b0;
        f.v = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/alu_add32.sv
// 32-bit parallel-prefix (Kogge-Stone) carry-lookahead adder.
// Exposes the final carry and the carry out of bit 30 for overflow detection.
module alu_add32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o,
    output logic        c30_o
);

    logic [31:0] g, p, gk, pk, gn, pn;
    logic [32:0] carry;

    always_comb begin
        g  = a_i & b_i;
        p  = a_i ^ b_i;
        gk = g;
        pk = p;
        for (int l = 0; l < 5; l++) begin
            gn = gk;
            pn = pk;
            for (int i = (1 << l); i < 32; i++) begin
                gn[i] = gk[i] | (pk[i] & gk[i - (1 << l)]);
                pn[i] = pk[i] & pk[i - (1 << l)];
            end
            gk = gn;
            pk = pn;
        end
        // carry[i] is the carry into bit i
        carry  = {gk | (pk & {32{cin_i}}), cin_i};
        sum_o  = p ^ carry[31:0];
        cout_o = carry[32];
        c30_o  = carry[31];
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU: one-cycle logic/add/sub, 32-iteration shift-add multiply.
// Requests are accepted only in IDLE; anything arriving while busy is dropped.
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_start,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        op_done,
    output logic [63:0] result,
    output logic        flag_n,
    output logic        flag_z,
    output logic        flag_c,
    output logic        flag_v
);

    state_e      state_q, state_d;
    opcode_e     opc_q, opc_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] res_q, res_d;
    flags_t      flg_q, flg_d;

    logic [31:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout, add_c30;

    logic [31:0] exec_res;
    flags_t      exec_flg;
    logic        mul_c;
    logic [31:0] mul_s;
    logic [63:0] mul_prod;

    // During MUL the adder accumulates the multiplicand into the upper half.
    always_comb begin
        add_a   = a_q;
        add_b   = b_q;
        add_cin = 1'b0;
        if (state_q == ST_MUL) begin
            add_a = hi_q;
            add_b = a_q;
        end else if (opc_q == OP_SUB) begin
            add_b   = ~b_q;
            add_cin = 1'b1;
        end
    end

    alu_add32 u_add (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout),
        .c30_o  (add_c30)
    );

    always_comb begin
        exec_res = '0;
        case (opc_q)
            OP_AND:  exec_res = a_q & b_q;
            OP_OR:   exec_res = a_q | b_q;
            OP_XOR:  exec_res = a_q ^ b_q;
            OP_XNOR: exec_res = ~(a_q ^ b_q);
            OP_NOTA: exec_res = ~a_q;
            OP_ADD:  exec_res = add_sum;
            OP_SUB:  exec_res = add_sum;
            default: exec_res = '0;
        endcase
        exec_flg = logic_flags(exec_res);
        if (opc_q == OP_ADD || opc_q == OP_SUB) begin
            exec_flg.c = add_cout;
            exec_flg.v = add_cout ^ add_c30;
        end
    end

    // One shift-add step: {carry, hi, multiplier} shifted right by one.
    always_comb begin
        mul_c = 1'b0;
        mul_s = hi_q;
        if (b_q[0]) begin
            mul_c = add_cout;
            mul_s = add_sum;
        end
        mul_prod = {mul_c, mul_s, b_q[31:1]};
    end

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        flg_d   = flg_q;
        case (state_q)
            ST_IDLE: begin
                if (op_start) begin
                    opc_d   = opcode_e'(op_code);
                    a_d     = op_a;
                    b_d     = op_b;
                    hi_d    = '0;
                    cnt_d   = '0;
                    state_d = (op_code == OP_MUL) ? ST_MUL : ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d   = {32'd0, exec_res};
                flg_d   = exec_flg;
                state_d = ST_DONE;
            end
            ST_MUL: begin
                hi_d  = mul_prod[63:32];
                b_d   = mul_prod[31:0];
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == MUL_LAST_CNT) begin
                    res_d   = mul_prod;
                    flg_d.n = mul_prod[63];
                    flg_d.z = (mul_prod == 64'd0);
                    flg_d.c = 1'b0;
                    flg_d.v = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            opc_q   <= OP_AND;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign op_done = (state_q == ST_DONE);
    assign result  = res_q;
    assign flag_n  = flg_q.n;
    assign flag_z  = flg_q.z;
    assign flag_c  = flg_q.c;
    assign flag_v  = flg_q.v;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus randomized checks of alu_sequencer against an arithmetic model.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        op_start;
    logic [2:0]  op_code;
    logic [31:0] op_a, op_b;
    logic        busy, op_done;
    logic [63:0] result;
    logic        flag_n, flag_z, flag_c, flag_v;

    int vectors = 0;
    int miscompares = 0;

    alu_sequencer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .op_start (op_start),
        .op_code  (op_code),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .op_done  (op_done),
        .result   (result),
        .flag_n   (flag_n),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .flag_v   (flag_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the opcode meaning; flags packed {N,Z,C,V}.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] r, output logic [3:0] f);
        logic [32:0] s33;
        logic        n, z, c, v;
        r = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: r = {32'd0, a & b};
            3'd1: r = {32'd0, a | b};
            3'd2: r = {32'd0, a ^ b};
            3'd3: r = {32'd0, ~(a ^ b)};
            3'd4: r = {32'd0, ~a};
            3'd5: begin
                s33 = {1'b0, a} + {1'b0, b};
                r = {32'd0, s33[31:0]};
                c = s33[32];
                v = (a[31] == b[31]) && (s33[31] != a[31]);
            end
            3'd6: begin
                s33 = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = {32'd0, s33[31:0]};
                c = s33[32];
                v = (a[31] != b[31]) && (s33[31] != a[31]);
            end
            default: r = {32'd0, a} * {32'd0, b};
        endcase
        if (op == 3'd7) begin
            n = r[63];
            z = (r == 64'd0);
        end else begin
            n = r[31];
            z = (r[31:0] == 32'd0);
        end
        f = {n, z, c, v};
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] er, input logic [3:0] ef, input string tag);
        int k;
        bit seen, busy_ok;
        @(negedge clk);
        op_start = 1'b1; op_code = op; op_a = a; op_b = b;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        op_code = 3'($urandom); op_a = $urandom; op_b = $urandom;
        k = 0; seen = 0; busy_ok = 1;
        while (!seen && k < 40) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 0;
            if (op_done === 1'b1) seen = 1;
            else begin
                @(posedge clk);
                k++;
            end
        end
        // op_done occupies the cycle that closes at edge E+latency
        chk({tag, " latency"}, 64'(k + 1), (op == 3'd7) ? 64'd33 : 64'd2);
        chk({tag, " busy"}, 64'(busy_ok), 64'd1);
        chk({tag, " result"}, result, er);
        chk({tag, " flags"}, {60'd0, flag_n, flag_z, flag_c, flag_v}, {60'd0, ef});
        @(negedge clk);
        chk({tag, " done pulse"}, {62'd0, op_done, busy}, 64'd0);
        chk({tag, " hold"}, result, er);
    endtask

    initial begin
        logic [63:0] er;
        logic [3:0]  ef;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [31:0] corner [0:5];
        bit          no_done;

        corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h0000_0001; corner[5] = 32'hDEAD_BEEF;

        reset_n = 1'b0; op_start = 1'b0; op_code = '0; op_a = '0; op_b = '0;
        #3;
        chk("reset outputs", {busy, op_done, flag_n, flag_z, flag_c, flag_v}, 64'd0);
        chk("reset result", result, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        run_op(3'd5, 32'h7FFF_FFFF, 32'h0000_0001, 64'h8000_0000, 4'b1001, "add_ovf");
        run_op(3'd6, 32'd5, 32'd5, 64'd0, 4'b0110, "sub_eq");
        run_op(3'd6, 32'd0, 32'd1, 64'hFFFF_FFFF, 4'b1000, "sub_borrow");
        run_op(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4'b1000, "mul_max");
        run_op(3'd4, 32'd0, 32'h1234_5678, 64'h0000_0000_FFFF_FFFF, 4'b1000, "not_zero");

        // Continuous request: one XOR per three cycles, extra requests dropped
        @(negedge clk);
        op_start = 1'b1; op_code = 3'd2; op_a = 32'hF0F0_F0F0; op_b = 32'hFFFF_0000;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("xor_stream op_done", {63'd0, op_done}, (i % 3 == 2) ? 64'd1 : 64'd0);
            if (i % 3 == 2) chk("xor_stream result", result, 64'h0F0F_F0F0);
        end
        op_start = 1'b0;

        // Reset in the middle of a multiply
        @(negedge clk);
        op_start = 1'b1; op_code = 3'd7; op_a = 32'd3; op_b = 32'd4;
        @(posedge clk);
        #1 op_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mul busy before reset", {63'd0, busy}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("midreset outputs", {busy, op_done, flag_n, flag_z, flag_c, flag_v}, 64'd0);
        chk("midreset result", result, 64'd0);
        no_done = 1;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (op_done !== 1'b0 || busy !== 1'b0) no_done = 0;
        end
        chk("midreset no done", 64'(no_done), 64'd1);
        run_op(3'd7, 32'd3, 32'd4, 64'd12, 4'b0000, "mul_after_reset");

        for (int t = 0; t < 30; t++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            model(op, a, b, er, ef);
            run_op(op, a, b, er, ef, $sformatf("rand%0d op%0d", t, op));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
